// File: rtl/ts_os_parser_if.sv
// ---------------------------------------------------------------------------
// ts_os_parser_if
// Bundles the ordered-set input word and the classified/extracted results
// exchanged between the ordered-set decoder side and the LTSSM side.
//   master : drives osValid, osIn, numberOfDetectedLanes, clearCount and
//            receives the parser results
//   slave  : the parser itself (consumes the word, drives the results)
// Result fields: outValid strobe, osType (0 none, 1 TS1, 2 TS2, 3 SKP,
// 4 EIOS, 7 BAD), lane-0 TS fields, per-lane lane numbers, consecutive-TS
// count, count>=8 level and an EIOS pulse.
// ---------------------------------------------------------------------------
interface ts_os_parser_if #(
    parameter int MAXLANES = 16,
    parameter int CNTWIDTH = 5
);
    logic                     osValid;
    logic [MAXLANES*128-1:0]  osIn;
    logic [4:0]               numberOfDetectedLanes;
    logic                     clearCount;
    logic                     outValid;
    logic [2:0]               osType;
    logic [7:0]               linkNum;
    logic [7:0]               nFts;
    logic [7:0]               rateId;
    logic [7:0]               trainCtrl;
    logic [MAXLANES*8-1:0]    laneNums;
    logic [CNTWIDTH-1:0]      tsCount;
    logic                     ts8Seen;
    logic                     eiosDet;

    modport master (
        output osValid, osIn, numberOfDetectedLanes, clearCount,
        input  outValid, osType, linkNum, nFts, rateId, trainCtrl,
               laneNums, tsCount, ts8Seen, eiosDet
    );

    modport slave (
        input  osValid, osIn, numberOfDetectedLanes, clearCount,
        output outValid, osType, linkNum, nFts, rateId, trainCtrl,
               laneNums, tsCount, ts8Seen, eiosDet
    );
endinterface

// File: rtl/ts_os_parser.sv
// ---------------------------------------------------------------------------
// ts_os_parser
// Classifies each lane-aligned Gen1/Gen2 ordered set (16 lanes x 16 symbols)
// as TS1, TS2, SKP, EIOS or BAD, checks cross-lane consistency, captures the
// lane-0 TS fields plus per-lane lane numbers, and counts consecutive
// identical TS sets for the LTSSM.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-low reset
//   bus    : ts_os_parser_if.slave (osValid/osIn/numberOfDetectedLanes/
//            clearCount in; outValid/osType/fields/laneNums/tsCount/
//            ts8Seen/eiosDet out)
// ---------------------------------------------------------------------------
module ts_os_parser #(
    parameter int MAXLANES = 16,
    parameter int CNTWIDTH = 5
) (
    input  logic          clk,
    input  logic          reset,
    ts_os_parser_if.slave bus
);
    localparam logic [2:0] TYPE_NONE = 3'd0;
    localparam logic [2:0] TYPE_TS1  = 3'd1;
    localparam logic [2:0] TYPE_TS2  = 3'd2;
    localparam logic [2:0] TYPE_SKP  = 3'd3;
    localparam logic [2:0] TYPE_EIOS = 3'd4;
    localparam logic [2:0] TYPE_BAD  = 3'd7;

    localparam logic [7:0] SYM_COM  = 8'hBC;
    localparam logic [7:0] SYM_TS1  = 8'h4A;
    localparam logic [7:0] SYM_TS2  = 8'h45;
    localparam logic [7:0] SYM_SKP  = 8'h1C;
    localparam logic [7:0] SYM_EIDL = 8'h7C;

    localparam logic [CNTWIDTH-1:0] CNT_ZERO = {CNTWIDTH{1'b0}};
    localparam logic [CNTWIDTH-1:0] CNT_ONE  = {{(CNTWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNTWIDTH-1:0] CNT_MAX  = {CNTWIDTH{1'b1}};

    // Type of one 16-symbol lane; TS patterns win over SKP/EIOS patterns.
    function automatic logic [2:0] classify_lane(input logic [127:0] lane);
        logic       all_ts1;
        logic       all_ts2;
        logic       all_skp;
        logic       all_eidl;
        logic [2:0] kind;
        all_ts1  = 1'b1;
        all_ts2  = 1'b1;
        all_skp  = 1'b1;
        all_eidl = 1'b1;
        for (int n = 6; n < 16; n++) begin
            all_ts1 = all_ts1 & (lane[8*n +: 8] == SYM_TS1);
            all_ts2 = all_ts2 & (lane[8*n +: 8] == SYM_TS2);
        end
        for (int n = 1; n < 4; n++) begin
            all_skp  = all_skp  & (lane[8*n +: 8] == SYM_SKP);
            all_eidl = all_eidl & (lane[8*n +: 8] == SYM_EIDL);
        end
        if (lane[7:0] != SYM_COM) begin
            kind = TYPE_BAD;
        end else if (all_ts1) begin
            kind = TYPE_TS1;
        end else if (all_ts2) begin
            kind = TYPE_TS2;
        end else if (all_skp) begin
            kind = TYPE_SKP;
        end else if (all_eidl) begin
            kind = TYPE_EIOS;
        end else begin
            kind = TYPE_BAD;
        end
        return kind;
    endfunction

    // Symbols 1, 3, 4, 5 (link, N_FTS, rate, training control) of a lane.
    function automatic logic [31:0] ts_fields(input logic [127:0] lane);
        return {lane[15:8], lane[31:24], lane[39:32], lane[47:40]};
    endfunction

    logic                    outValid_q,  outValid_d;
    logic [2:0]              osType_q,    osType_d;
    logic [7:0]              linkNum_q,   linkNum_d;
    logic [7:0]              nFts_q,      nFts_d;
    logic [7:0]              rateId_q,    rateId_d;
    logic [7:0]              trainCtrl_q, trainCtrl_d;
    logic [MAXLANES*8-1:0]   laneNums_q,  laneNums_d;
    logic [CNTWIDTH-1:0]     tsCount_q,   tsCount_d;
    logic                    eiosDet_q,   eiosDet_d;
    logic [2:0]              hist_type_q, hist_type_d;   // TYPE_NONE = empty
    logic [31:0]             hist_fields_q, hist_fields_d;

    logic [4:0]              n_lanes_s;
    logic [2:0]              lane0_type_s;
    logic [31:0]             fields0_s;
    logic [2:0]              word_type_s;
    logic [MAXLANES*8-1:0]   lane_nums_s;
    logic [CNTWIDTH-1:0]     base_count_s;
    logic [2:0]              base_type_s;
    logic [31:0]             base_fields_s;

    assign lane0_type_s = classify_lane(bus.osIn[127:0]);
    assign fields0_s    = ts_fields(bus.osIn[127:0]);

    // Active lane count; anything other than 1/2/4/8/16 falls back to one lane.
    always_comb begin
        case (bus.numberOfDetectedLanes)
            5'd1, 5'd2, 5'd4, 5'd8, 5'd16: n_lanes_s = bus.numberOfDetectedLanes;
            default:                       n_lanes_s = 5'd1;
        endcase
    end

    // Cross-lane consistency against lane 0 and lane-number gathering.
    always_comb begin
        logic word_bad;
        word_bad    = 1'b0;
        lane_nums_s = {(MAXLANES*8){1'b0}};
        for (int k = 0; k < MAXLANES; k++) begin
            if (5'(k) < n_lanes_s) begin
                lane_nums_s[8*k +: 8] = bus.osIn[128*k+16 +: 8];
                if (classify_lane(bus.osIn[128*k +: 128]) != lane0_type_s) begin
                    word_bad = 1'b1;
                end else if (((lane0_type_s == TYPE_TS1) || (lane0_type_s == TYPE_TS2)) &&
                             (ts_fields(bus.osIn[128*k +: 128]) != fields0_s)) begin
                    word_bad = 1'b1;
                end else begin
                    word_bad = word_bad;
                end
            end else begin
                lane_nums_s[8*k +: 8] = 8'h00;
            end
        end
        word_type_s = word_bad ? TYPE_BAD : lane0_type_s;
    end

    // clearCount takes effect before the same-cycle ordered set is processed.
    always_comb begin
        if (bus.clearCount) begin
            base_count_s  = CNT_ZERO;
            base_type_s   = TYPE_NONE;
            base_fields_s = 32'h0000_0000;
        end else begin
            base_count_s  = tsCount_q;
            base_type_s   = hist_type_q;
            base_fields_s = hist_fields_q;
        end
    end

    // Next-state for all result registers, counter and history.
    always_comb begin
        outValid_d    = 1'b0;
        eiosDet_d     = 1'b0;
        osType_d      = osType_q;
        linkNum_d     = linkNum_q;
        nFts_d        = nFts_q;
        rateId_d      = rateId_q;
        trainCtrl_d   = trainCtrl_q;
        laneNums_d    = laneNums_q;
        tsCount_d     = base_count_s;
        hist_type_d   = base_type_s;
        hist_fields_d = base_fields_s;
        if (bus.osValid) begin
            outValid_d = 1'b1;
            osType_d   = word_type_s;
            case (word_type_s)
                TYPE_TS1, TYPE_TS2: begin
                    linkNum_d   = fields0_s[31:24];
                    nFts_d      = fields0_s[23:16];
                    rateId_d    = fields0_s[15:8];
                    trainCtrl_d = fields0_s[7:0];
                    laneNums_d  = lane_nums_s;
                    if ((base_type_s == word_type_s) && (base_fields_s == fields0_s)) begin
                        tsCount_d = (base_count_s == CNT_MAX) ? CNT_MAX : (base_count_s + CNT_ONE);
                    end else begin
                        tsCount_d     = CNT_ONE;
                        hist_type_d   = word_type_s;
                        hist_fields_d = fields0_s;
                    end
                end
                TYPE_SKP: begin
                    tsCount_d = base_count_s;
                end
                TYPE_EIOS: begin
                    tsCount_d     = CNT_ZERO;
                    hist_type_d   = TYPE_NONE;
                    hist_fields_d = 32'h0000_0000;
                    eiosDet_d     = 1'b1;
                end
                default: begin
                    tsCount_d     = CNT_ZERO;
                    hist_type_d   = TYPE_NONE;
                    hist_fields_d = 32'h0000_0000;
                end
            endcase
        end else begin
            outValid_d = 1'b0;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            outValid_q    <= 1'b0;
            osType_q      <= TYPE_NONE;
            linkNum_q     <= 8'h00;
            nFts_q        <= 8'h00;
            rateId_q      <= 8'h00;
            trainCtrl_q   <= 8'h00;
            laneNums_q    <= {(MAXLANES*8){1'b0}};
            tsCount_q     <= CNT_ZERO;
            eiosDet_q     <= 1'b0;
            hist_type_q   <= TYPE_NONE;
            hist_fields_q <= 32'h0000_0000;
        end else begin
            outValid_q    <= outValid_d;
            osType_q      <= osType_d;
            linkNum_q     <= linkNum_d;
            nFts_q        <= nFts_d;
            rateId_q      <= rateId_d;
            trainCtrl_q   <= trainCtrl_d;
            laneNums_q    <= laneNums_d;
            tsCount_q     <= tsCount_d;
            eiosDet_q     <= eiosDet_d;
            hist_type_q   <= hist_type_d;
            hist_fields_q <= hist_fields_d;
        end
    end

    assign bus.outValid  = outValid_q;
    assign bus.osType    = osType_q;
    assign bus.linkNum   = linkNum_q;
    assign bus.nFts      = nFts_q;
    assign bus.rateId    = rateId_q;
    assign bus.trainCtrl = trainCtrl_q;
    assign bus.laneNums  = laneNums_q;
    assign bus.tsCount   = tsCount_q;
    assign bus.eiosDet   = eiosDet_q;
    assign bus.ts8Seen   = ({{(32-CNTWIDTH){1'b0}}, tsCount_q} >= 32'd8);

endmodule

// File: tb/tb_ts_os_parser.sv
// ---------------------------------------------------------------------------
// tb_ts_os_parser
// Table of directed ordered-set vectors with hand-derived expectations,
// hand-written multi-cycle sequences (field hold, clear, saturation, reset
// mid-stream) and a randomized phase, all checked against a behavioural
// model that works on a symbol array per lane.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ts_os_parser;
    localparam int MAXLANES = 16;
    localparam int CNTWIDTH = 5;
    localparam int CNT_MAX  = (1 << CNTWIDTH) - 1;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ts_os_parser_if #(.MAXLANES(MAXLANES), .CNTWIDTH(CNTWIDTH)) bus ();
    ts_os_parser #(.MAXLANES(MAXLANES), .CNTWIDTH(CNTWIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] sym [MAXLANES][16];

    // behavioural model state
    bit           m_ov, m_eios, m_hv;
    int           m_type, m_cnt, m_ht;
    logic [7:0]   m_link, m_nfts, m_rate, m_ctrl;
    logic [127:0] m_lanes;
    logic [31:0]  m_hf;

    typedef struct {
        int kind;      // 0 TS1, 1 TS2, 2 SKP, 3 EIOS, 4 TS1 with lane2 link 01
        int nl;
        bit vld;
        bit clr;
        int exp_type;
        int exp_cnt;
        bit exp_eios;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        n_vec++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    function automatic int lane_type(int k);
        bit t1 = 1'b1, t2 = 1'b1, sk = 1'b1, ei = 1'b1;
        if (sym[k][0] != 8'hBC) return 7;
        for (int n = 6; n < 16; n++) begin
            if (sym[k][n] != 8'h4A) t1 = 1'b0;
            if (sym[k][n] != 8'h45) t2 = 1'b0;
        end
        for (int n = 1; n < 4; n++) begin
            if (sym[k][n] != 8'h1C) sk = 1'b0;
            if (sym[k][n] != 8'h7C) ei = 1'b0;
        end
        if (t1) return 1;
        if (t2) return 2;
        if (sk) return 3;
        if (ei) return 4;
        return 7;
    endfunction

    function automatic int eff_lanes(int nl);
        return (nl == 1 || nl == 2 || nl == 4 || nl == 8 || nl == 16) ? nl : 1;
    endfunction

    function automatic logic [31:0] fld(int k);
        return {sym[k][1], sym[k][3], sym[k][4], sym[k][5]};
    endfunction

    function automatic int word_type(int nl);
        int t0 = lane_type(0);
        for (int k = 1; k < eff_lanes(nl); k++) begin
            if (lane_type(k) != t0) return 7;
            if ((t0 == 1 || t0 == 2) && fld(k) != fld(0)) return 7;
        end
        return t0;
    endfunction

    task automatic model_reset();
        m_ov = 0; m_eios = 0; m_hv = 0; m_type = 0; m_cnt = 0; m_ht = 0;
        m_link = 0; m_nfts = 0; m_rate = 0; m_ctrl = 0; m_lanes = '0; m_hf = '0;
    endtask

    task automatic model_step(input bit v, input bit c, input int nl);
        int t;
        m_ov = v; m_eios = 0;
        if (c) begin m_cnt = 0; m_hv = 0; end
        if (v) begin
            t = word_type(nl);
            m_type = t;
            if (t == 1 || t == 2) begin
                m_link = sym[0][1]; m_nfts = sym[0][3]; m_rate = sym[0][4]; m_ctrl = sym[0][5];
                m_lanes = '0;
                for (int k = 0; k < eff_lanes(nl); k++) m_lanes[8*k +: 8] = sym[k][2];
                if (m_hv && m_ht == t && m_hf == fld(0)) begin
                    if (m_cnt < CNT_MAX) m_cnt++;
                end else begin
                    m_cnt = 1; m_hv = 1; m_ht = t; m_hf = fld(0);
                end
            end else if (t == 4) begin
                m_cnt = 0; m_hv = 0; m_eios = 1;
            end else if (t == 7) begin
                m_cnt = 0; m_hv = 0;
            end
        end
    endtask

    task automatic check_all();
        chk("outValid",  bus.outValid,  m_ov);
        chk("osType",    bus.osType,    m_type);
        chk("linkNum",   bus.linkNum,   m_link);
        chk("nFts",      bus.nFts,      m_nfts);
        chk("rateId",    bus.rateId,    m_rate);
        chk("trainCtrl", bus.trainCtrl, m_ctrl);
        chk("laneNums",  bus.laneNums,  m_lanes);
        chk("tsCount",   bus.tsCount,   m_cnt);
        chk("ts8Seen",   bus.ts8Seen,   (m_cnt >= 8));
        chk("eiosDet",   bus.eiosDet,   m_eios);
    endtask

    task automatic fill_ts(input logic [7:0] pat, input logic [7:0] link, input logic [7:0] nfts,
                           input logic [7:0] rate, input logic [7:0] ctrl);
        for (int k = 0; k < MAXLANES; k++) begin
            sym[k][0] = 8'hBC; sym[k][1] = link; sym[k][2] = 8'(k);
            sym[k][3] = nfts;  sym[k][4] = rate; sym[k][5] = ctrl;
            for (int n = 6; n < 16; n++) sym[k][n] = pat;
        end
    endtask

    task automatic fill_os(input logic [7:0] b);
        for (int k = 0; k < MAXLANES; k++) begin
            sym[k][0] = 8'hBC;
            for (int n = 1; n < 16; n++) sym[k][n] = b;
        end
    endtask

    task automatic build_word(input int kind);
        case (kind)
            1:       fill_ts(8'h45, 8'h00, 8'h20, 8'h02, 8'h00);
            2:       fill_os(8'h1C);
            3:       fill_os(8'h7C);
            4: begin
                fill_ts(8'h4A, 8'h00, 8'h20, 8'h02, 8'h00);
                sym[2][1] = 8'h01;
            end
            default: fill_ts(8'h4A, 8'h00, 8'h20, 8'h02, 8'h00);
        endcase
    endtask

    // Apply one cycle of inputs, step the model at the edge, check #1 later.
    task automatic cycle(input bit v, input bit c, input int nl);
        bus.osValid = v;
        bus.clearCount = c;
        bus.numberOfDetectedLanes = 5'(nl);
        for (int k = 0; k < MAXLANES; k++)
            for (int n = 0; n < 16; n++)
                bus.osIn[128*k + 8*n +: 8] = sym[k][n];
        @(posedge clk);
        model_step(v, c, nl);
        #1;
        check_all();
        bus.osValid = 1'b0;
        bus.clearCount = 1'b0;
    endtask

    task automatic add(input int kind, input int nl, input bit vld, input bit clr,
                       input int et, input int ec, input bit ee);
        vec_t v;
        v.kind = kind; v.nl = nl; v.vld = vld; v.clr = clr;
        v.exp_type = et; v.exp_cnt = ec; v.exp_eios = ee;
        tbl.push_back(v);
    endtask

    initial begin
        logic [127:0] lanes16;
        int exp_cnt;
        reset = 1'b0;
        bus.osValid = 1'b0;
        bus.clearCount = 1'b0;
        bus.numberOfDetectedLanes = 5'd0;
        bus.osIn = '0;
        fill_os(8'h00);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // ---------------- directed table ----------------
        for (int i = 1; i <= 10; i++) add(0, 4, 1, 0, 1, i, 0);
        add(1, 4, 1, 0, 2, 1, 0);
        add(1, 4, 1, 0, 2, 2, 0);
        add(1, 4, 1, 0, 2, 3, 0);
        add(3, 4, 1, 0, 4, 0, 1);
        add(0, 4, 0, 0, 4, 0, 0);
        add(1, 4, 1, 0, 2, 1, 0);
        add(4, 4, 1, 0, 7, 0, 0);
        add(0, 2, 1, 0, 1, 1, 0);
        add(0, 2, 1, 0, 1, 2, 0);
        add(0, 2, 1, 0, 1, 3, 0);
        add(2, 2, 1, 0, 3, 3, 0);
        add(0, 2, 1, 0, 1, 4, 0);
        add(0, 2, 1, 0, 1, 5, 0);
        add(0, 2, 0, 1, 1, 0, 0);
        add(0, 2, 1, 0, 1, 1, 0);
        add(0, 2, 1, 0, 1, 2, 0);
        add(0, 2, 1, 1, 1, 1, 0);
        add(0, 2, 1, 0, 1, 2, 0);
        add(4, 3, 1, 0, 1, 3, 0);
        add(4, 8, 1, 0, 7, 0, 0);
        add(0, 0, 1, 0, 1, 1, 0);

        foreach (tbl[i]) begin
            build_word(tbl[i].kind);
            cycle(tbl[i].vld, tbl[i].clr, tbl[i].nl);
            chk("tbl_type",  bus.osType,  tbl[i].exp_type);
            chk("tbl_count", bus.tsCount, tbl[i].exp_cnt);
            chk("tbl_ts8",   bus.ts8Seen, (tbl[i].exp_cnt >= 8));
            chk("tbl_eios",  bus.eiosDet, tbl[i].exp_eios);
            if (i == 9) chk("tbl_laneNums4", bus.laneNums, 128'h03020100);
        end

        // ---------------- fields hold on BAD and SKP ----------------
        fill_ts(8'h4A, 8'h05, 8'h11, 8'h02, 8'h00);
        cycle(1, 0, 4);
        fill_ts(8'h4A, 8'h09, 8'h33, 8'h02, 8'h00);
        sym[1][1] = 8'h0A;
        cycle(1, 0, 4);
        chk("bad_type",    bus.osType,  7);
        chk("bad_linkNum", bus.linkNum, 8'h05);
        chk("bad_nFts",    bus.nFts,    8'h11);
        fill_os(8'h1C);
        cycle(1, 0, 4);
        chk("skp_type",    bus.osType,  3);
        chk("skp_linkNum", bus.linkNum, 8'h05);

        // ---------------- 16 lanes: clear, saturation, reset mid-stream -------
        lanes16 = '0;
        for (int k = 0; k < MAXLANES; k++) lanes16[8*k +: 8] = 8'(k);
        exp_cnt = 0;
        fill_ts(8'h4A, 8'h00, 8'h20, 8'h02, 8'h00);
        for (int i = 1; i <= 60; i++) begin
            cycle(1, (i == 20), 16);
            if (i == 20) exp_cnt = 1;
            else if (exp_cnt < CNT_MAX) exp_cnt++;
            chk("seq_count", bus.tsCount, exp_cnt);
            chk("seq_ts8",   bus.ts8Seen, (exp_cnt >= 8));
            if (i == 1) chk("seq_laneNums16", bus.laneNums, lanes16);
            if (i == 55) begin
                #2 reset = 1'b0;
                #1;
                model_reset();
                check_all();
                chk("rst_count", bus.tsCount, 0);
                chk("rst_type",  bus.osType,  0);
                #2 reset = 1'b1;
                exp_cnt = 0;
            end
        end

        // ---------------- randomized phase ----------------
        for (int r = 0; r < 600; r++) begin
            int kind, nl;
            bit v, c;
            logic [7:0] link, nfts, ctrl;
            case ($urandom_range(0, 5))
                0: nl = 1;
                1: nl = 2;
                2: nl = 4;
                3: nl = 8;
                4: nl = 16;
                default: nl = $urandom_range(0, 31);
            endcase
            link = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 2)) : 8'h00;
            nfts = ($urandom_range(0, 3) == 0) ? 8'h21 : 8'h20;
            ctrl = ($urandom_range(0, 5) == 0) ? 8'h01 : 8'h00;
            kind = $urandom_range(0, 9);
            if (kind <= 3)      fill_ts(8'h4A, link, nfts, 8'h02, ctrl);
            else if (kind <= 5) fill_ts(8'h45, link, nfts, 8'h02, ctrl);
            else if (kind == 6) fill_os(8'h1C);
            else if (kind == 7) fill_os(8'h7C);
            else if (kind == 8) begin
                fill_ts(8'h4A, link, nfts, 8'h02, ctrl);
                sym[$urandom_range(0, 15)][$urandom_range(0, 15)] = 8'($urandom_range(0, 255));
            end else begin
                fill_ts(8'h45, link, nfts, 8'h02, ctrl);
                sym[$urandom_range(1, 15)][$urandom_range(3, 5)] = 8'h7F;
            end
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 15) == 0);
            cycle(v, c, nl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
